// File: rtl/uart_rx_os_if.sv
// Parallel result bundle of the oversampling UART receiver.
// The receiver drives it through master; the consumer reads it through slave.
interface uart_rx_os_if #(
  parameter int DBIT = 8
);
  logic [DBIT-1:0] dout;
  logic            rx_done_tick;
  logic            frame_err;
  logic            parity_err;

  modport master (
    output dout,
    output rx_done_tick,
    output frame_err,
    output parity_err
  );

  modport slave (
    input dout,
    input rx_done_tick,
    input frame_err,
    input parity_err
  );
endinterface

// File: rtl/uart_rx_os.sv
// Oversampling UART receiver, 16 sample ticks per bit, LSB first.
// Optional parity bit; results and status held until the next frame.
module uart_rx_os #(
  parameter int DBIT       = 8,
  parameter int SB_TICK    = 16,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         rx,
  input  logic         s_tick,
  uart_rx_os_if.master bus
);
  localparam int SMAX = (SB_TICK > 16) ? SB_TICK : 16;
  localparam int SW   = $clog2(SMAX);
  localparam int NW   = $clog2(DBIT);

  localparam logic [SW-1:0] S_MID  = SW'(7);
  localparam logic [SW-1:0] S_END  = SW'(15);
  localparam logic [SW-1:0] S_STOP = SW'(SB_TICK - 1);
  localparam logic [NW-1:0] N_LAST = NW'(DBIT - 1);
  localparam logic          P_EN   = (PARITY_EN != 0);
  localparam logic          P_ODD  = (PARITY_ODD != 0);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  state_t          state;
  logic [SW-1:0]   s;
  logic [NW-1:0]   n;
  logic [DBIT-1:0] b;
  logic            pbit;
  logic [1:0]      sync;
  logic            rx_s;

  assign rx_s = sync[1];

  always_ff @(posedge clk) begin
    if (!rst) begin
      state            <= IDLE;
      s                <= '0;
      n                <= '0;
      b                <= '0;
      pbit             <= 1'b0;
      sync             <= 2'b11;
      bus.dout         <= '0;
      bus.rx_done_tick <= 1'b0;
      bus.frame_err    <= 1'b0;
      bus.parity_err   <= 1'b0;
    end else begin
      sync             <= {sync[0], rx};
      bus.rx_done_tick <= 1'b0;
      unique case (state)
        // edge detect runs every clk; a coincident tick is not counted
        IDLE: begin
          if (!rx_s) begin
            state <= START;
            s     <= '0;
          end
        end
        START: begin
          if (s_tick) begin
            if (s == S_MID) begin
              if (!rx_s) begin
                state <= DATA;
                s     <= '0;
                n     <= '0;
              end else begin
                state <= IDLE;
              end
            end else begin
              s <= s + 1'b1;
            end
          end
        end
        DATA: begin
          if (s_tick) begin
            if (s == S_END) begin
              b <= {rx_s, b[DBIT-1:1]};
              s <= '0;
              if (n == N_LAST)
                state <= P_EN ? PARITY : STOP;
              else
                n <= n + 1'b1;
            end else begin
              s <= s + 1'b1;
            end
          end
        end
        PARITY: begin
          if (s_tick) begin
            if (s == S_END) begin
              pbit  <= rx_s;
              s     <= '0;
              state <= STOP;
            end else begin
              s <= s + 1'b1;
            end
          end
        end
        STOP: begin
          if (s_tick) begin
            if (s == S_STOP) begin
              state            <= IDLE;
              bus.dout         <= b;
              bus.frame_err    <= ~rx_s;
              bus.parity_err   <= P_EN & (^b ^ pbit ^ P_ODD);
              bus.rx_done_tick <= 1'b1;
            end else begin
              s <= s + 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_uart_rx_os.sv
// Directed bench for uart_rx_os: no-parity and even-parity instances,
// frame expectations queued at send time and popped on each done pulse.
module tb_uart_rx_os;
  logic clk    = 1'b0;
  logic rst    = 1'b0;
  logic rx0    = 1'b1;
  logic rx1    = 1'b1;
  logic s_tick = 1'b0;

  uart_rx_os_if #(.DBIT(8)) if0 ();
  uart_rx_os_if #(.DBIT(8)) if1 ();

  uart_rx_os #(
    .DBIT(8), .SB_TICK(16), .PARITY_EN(0), .PARITY_ODD(0)
  ) dut0 (
    .clk(clk), .rst(rst), .rx(rx0), .s_tick(s_tick), .bus(if0.master)
  );

  uart_rx_os #(
    .DBIT(8), .SB_TICK(16), .PARITY_EN(1), .PARITY_ODD(0)
  ) dut1 (
    .clk(clk), .rst(rst), .rx(rx1), .s_tick(s_tick), .bus(if1.master)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] d;
    logic       fe;
    logic       pe;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  int   checks = 0;
  int   errors = 0;
  int   dones0 = 0;
  int   dones1 = 0;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // one tick every 4 clk -> one bit per 64 clk
  initial begin
    int c = 0;
    forever begin
      @(negedge clk);
      s_tick = (c == 3);
      c = (c + 1) % 4;
    end
  end

  always @(negedge clk) begin : mon
    exp_t e;
    if (if0.rx_done_tick === 1'b1) begin
      dones0++;
      if (q0.size() == 0) begin
        chk("unexpected_done0", 32'd1, 32'd0);
      end else begin
        e = q0.pop_front();
        chk("dout0", 32'(if0.dout), 32'(e.d));
        chk("frame_err0", 32'(if0.frame_err), 32'(e.fe));
        chk("parity_err0", 32'(if0.parity_err), 32'(e.pe));
      end
    end
    if (if1.rx_done_tick === 1'b1) begin
      dones1++;
      if (q1.size() == 0) begin
        chk("unexpected_done1", 32'd1, 32'd0);
      end else begin
        e = q1.pop_front();
        chk("dout1", 32'(if1.dout), 32'(e.d));
        chk("frame_err1", 32'(if1.frame_err), 32'(e.fe));
        chk("parity_err1", 32'(if1.parity_err), 32'(e.pe));
      end
    end
  end

  task automatic drive(input bit sel, input logic v, input int n);
    if (sel) rx1 = v;
    else     rx0 = v;
    repeat (n) @(negedge clk);
  endtask

  task automatic send(input bit sel, input logic [7:0] d,
                      input bit par, input bit pb,
                      input bit stopv, input int stop_clk,
                      input int abort_bit);
    drive(sel, 1'b0, 64);
    for (int i = 0; i < 8; i++) begin
      if (i == abort_bit) begin
        drive(sel, d[i], 32);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        chk("rst_dout", 32'(if0.dout), 32'h0);
        chk("rst_frame_err", 32'(if0.frame_err), 32'h0);
        chk("rst_parity_err", 32'(if0.parity_err), 32'h0);
        chk("rst_parity_err1", 32'(if1.parity_err), 32'h0);
        drive(sel, d[i], 31);
      end else begin
        drive(sel, d[i], 64);
      end
    end
    if (par) drive(sel, pb, 64);
    drive(sel, stopv, stop_clk);
    if (sel) rx1 = 1'b1;
    else     rx0 = 1'b1;
  endtask

  task automatic frame0(input logic [7:0] d, input bit stopv,
                        input int stop_clk);
    exp_t e;
    e.d  = d;
    e.fe = ~stopv;
    e.pe = 1'b0;
    q0.push_back(e);
    send(1'b0, d, 1'b0, 1'b0, stopv, stop_clk, -1);
  endtask

  task automatic frame1(input logic [7:0] d, input bit pb);
    exp_t e;
    e.d  = d;
    e.fe = 1'b0;
    e.pe = ^d ^ pb;
    q1.push_back(e);
    send(1'b1, d, 1'b1, pb, 1'b1, 64, -1);
  endtask

  task automatic drain(input string tag);
    int k = 0;
    while ((q0.size() != 0 || q1.size() != 0) && k < 300) begin
      @(negedge clk);
      k++;
    end
    chk(tag, 32'(q0.size() + q1.size()), 32'd0);
  endtask

  initial begin
    int d0;
    int d1;
    repeat (3) @(negedge clk);
    chk("reset_dout", 32'(if0.dout), 32'h0);
    chk("reset_done", 32'(if0.rx_done_tick), 32'h0);
    chk("reset_frame_err", 32'(if0.frame_err), 32'h0);
    chk("reset_parity_err", 32'(if0.parity_err), 32'h0);
    chk("reset_dout1", 32'(if1.dout), 32'h0);
    rst = 1'b1;
    repeat (10) @(negedge clk);

    d0 = dones0;
    drive(1'b0, 1'b0, 20);
    drive(1'b0, 1'b1, 100);
    chk("glitch_no_done", 32'(dones0 - d0), 32'd0);
    chk("glitch_dout", 32'(if0.dout), 32'h0);

    d0 = dones0;
    frame0(8'hA5, 1'b1, 64);
    drain("drain_a5");
    chk("a5_one_done", 32'(dones0 - d0), 32'd1);

    d0 = dones0;
    frame0(8'h3C, 1'b0, 40);
    drive(1'b0, 1'b1, 100);
    drain("drain_3c");
    chk("3c_one_done", 32'(dones0 - d0), 32'd1);

    frame0(8'h55, 1'b1, 64);
    drain("drain_55");

    d1 = dones1;
    frame1(8'h07, 1'b1);
    drain("drain_par_ok");
    frame1(8'h07, 1'b0);
    drain("drain_par_bad");
    chk("parity_dones", 32'(dones1 - d1), 32'd2);

    d0 = dones0;
    send(1'b0, 8'hFF, 1'b0, 1'b0, 1'b1, 64, 4);
    drive(1'b0, 1'b1, 100);
    chk("abort_no_done", 32'(dones0 - d0), 32'd0);
    chk("abort_dout", 32'(if0.dout), 32'h0);
    frame0(8'h81, 1'b1, 64);
    drain("drain_81");

    d0 = dones0;
    frame0(8'h01, 1'b1, 64);
    frame0(8'h80, 1'b1, 64);
    frame0(8'hFE, 1'b1, 64);
    drain("drain_b2b");
    chk("b2b_dones", 32'(dones0 - d0), 32'd3);
    chk("final_frame_err", 32'(if0.frame_err), 32'h0);

    repeat (20) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/uart_rx_os.md
Name: uart_rx_os

Overview:
Oversampling UART receiver for the serial link of the blackjack console. It consumes the baud-rate sample tick from the mod-M baud generator (16 ticks per bit) and deserialises the asynchronous rx line into parallel bytes. Each received frame is presented with a one-cycle done strobe plus framing and parity status, for the downstream FIFO / command decoder.

Parameters:
DBIT, 8, number of data bits per frame (5..9), LSB first
SB_TICK, 16, sample ticks spent in the stop state (16 = 1 stop bit, 24 = 1.5, 32 = 2)
PARITY_EN, 0, 1 = one parity bit follows the data bits
PARITY_ODD, 0, 0 = even parity, 1 = odd parity (ignored when PARITY_EN=0)

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  reset, synchronous, active-low (asserted when 0)
rx  input  1  asynchronous serial input, idle high
s_tick  input  1  oversample strobe, 1 clk wide, 16 per bit period (from the baud generator's max_tick)
dout  output  DBIT  last received data word
rx_done_tick  output  1  one-clk pulse, new frame completed
frame_err  output  1  stop bit sampled 0 on last frame
parity_err  output  1  parity mismatch on last frame (always 0 when PARITY_EN=0)

Behaviour:
- Reset: synchronous, active-low; takes effect on the clk edge where rst=0 and overrides all other activity. state=IDLE; tick counter s=0; bit counter n=0; shift reg=0; dout=0; rx_done_tick=0; frame_err=0; parity_err=0; both synchroniser flops=1.
- Input sync: rx passes through a 2-FF synchroniser, giving rx_s. All decisions use rx_s, so there are 2 clk of latency from rx.
- s and n advance only on clk cycles with s_tick=1. Other cycles hold all state except the IDLE edge detect.
- IDLE:
  - rx_s==0 (checked every clk, independent of s_tick) -> START, s=0.
- START:
  - On s_tick with s==7 (mid start bit): rx_s==0 -> DATA, s=0, n=0.
  - rx_s==1 (glitch) -> IDLE with no output change.
  - Otherwise s++.
- DATA:
  - On s_tick with s==15: shift reg = {rx_s, shift[DBIT-1:1]} (LSB first), s=0.
  - If n==DBIT-1 -> PARITY (PARITY_EN=1) or STOP; else n++.
  - Otherwise s++.
- PARITY:
  - On s_tick with s==15: capture rx_s as parity bit, s=0 -> STOP.
- STOP:
  - On s_tick with s==SB_TICK-1: update registered outputs and go to IDLE.
    - dout=shift reg.
    - frame_err=~rx_s.
    - parity_err = PARITY_EN & (^data ^ pbit ^ PARITY_ODD) != 0.
    - rx_done_tick=1 for exactly the next clk cycle.
  - Otherwise s++.
- dout, frame_err and parity_err hold their values until the next frame completes. A glitch-aborted frame does not alter them.
- A frame with a framing error still completes and pulses rx_done_tick. If rx_s stays low after a bad stop bit, IDLE re-enters START immediately (break condition); the same glitch rule applies.
- s width is sized to hold max(15, SB_TICK-1). There is no wrap-around beyond the compare values.
- s_tick high in the same cycle as the IDLE->START transition is not counted.
- rst asserted mid-frame aborts the frame with no rx_done_tick. The next frame is received normally after release.
- Back-to-back frames: a start bit immediately following the stop sample is accepted. No dead time beyond the remaining stop ticks.

Test Plan:
- s_tick every 4 clk (bit = 64 clk), DBIT=8, send 0xA5 with 1 stop -> exactly one rx_done_tick; dout=0xA5; frame_err=0; parity_err=0.
- rx low for 20 clk then high (glitch shorter than half a bit) -> no rx_done_tick; FSM back in IDLE; dout keeps its previous value (0x00 after reset).
- Send 0x3C with stop bit 0, then rx high -> rx_done_tick once; dout=0x3C; frame_err=1. Next clean frame 0x55 -> frame_err=0.
- PARITY_EN=1, PARITY_ODD=0: send 0x07 with parity bit 1 -> parity_err=0. Send 0x07 with parity bit 0 -> parity_err=1.
- Drive rst=0 for 1 clk during data bit 4 of 0xFF -> no done pulse; all outputs 0. Following frame 0x81 -> dout=0x81.
- Three back-to-back frames 0x01, 0x80, 0xFE with no idle gap -> three done pulses ~640 clk apart; dout sequence matches and no errors.
